step_core: RTL and testbench

STEP_CORE -- requirements
Module: step_core

---
 rtl/step_core.sv | 124 ++++++++++++
 tb/tb_step_core.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_core.sv
// step_core: four-register stepping core with an 8-bit ISA (ADD/LOAD/STORE/JUMP).
// One instruction per fetch/exec pair; data memory reloads its pattern on reset.
module step_core #(
  parameter int DATA_W = 8,
  parameter int MEM_AW = 5,
  parameter int PC_W = 8
) (
  input  logic              oscillator,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic [PC_W-1:0]   instr_addr,
  output logic              instr_req,
  input  logic              instr_valid,
  input  logic [7:0]        instruction,
  output logic [1:0]        op,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic [1:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic              halted,
  input  logic [MEM_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int DEPTH = 1 << MEM_AW;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, imm_p;
  logic [7:0] ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ra, rb, ld, wb_data_q, wb_data_d;
  logic [MEM_AW-1:0] addr;
  logic [1:0] op_q, op_d, wb_reg_q, wb_reg_d;
  logic [2:0] strb_q, strb_d;
  logic step_q, mem_we, self_jump;
  assign ra = regs_q[ir_q[5:4]];
  assign rb = regs_q[ir_q[3:2]];
  assign addr = MEM_AW'(ra) + {{(MEM_AW-2){ir_q[1]}}, ir_q[1:0]};
  assign imm_p = {{(PC_W-2){ir_q[1]}}, ir_q[1:0]};
  assign ld = mem_q[addr];
  assign mem_we = state_q == EXEC && ir_q[7:6] == 2'b10;
  assign self_jump = ir_q[7:6] == 2'b11 && ir_q[1:0] == 2'b11;
  assign instr_addr = pc_q;
  assign instr_req = state_q == FETCH;
  assign halted = state_q == HALT;
  assign op = op_q;
  assign {mem_read, mem_write, reg_write} = strb_q;
  assign wb_valid = strb_q[0];
  assign wb_reg = wb_reg_q;
  assign wb_data = wb_data_q;
  assign dbg_data = mem_q[dbg_addr];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    regs_d = regs_q;
    op_d = op_q;
    strb_d = 3'b000;
    wb_reg_d = wb_reg_q;
    wb_data_d = wb_data_q;
    case (state_q)
      IDLE: state_d = (run || (step && !step_q)) ? FETCH : IDLE;
      FETCH: begin
        ir_d = instr_valid ? instruction : ir_q;
        state_d = instr_valid ? EXEC : FETCH;
      end
      EXEC: begin
        op_d = ir_q[7:6];
        pc_d = pc_q + PC_W'(1) + (ir_q[7:6] == 2'b11 ? imm_p : '0);
        state_d = self_jump ? HALT : run ? FETCH : IDLE;
        if (ir_q[7:6] == 2'b00) begin
          regs_d[ir_q[1:0]] = ra + rb;
          strb_d = 3'b001;
          wb_reg_d = ir_q[1:0];
          wb_data_d = ra + rb;
        end else if (ir_q[7:6] == 2'b01) begin
          regs_d[ir_q[3:2]] = ld;
          strb_d = 3'b101;
          wb_reg_d = ir_q[3:2];
          wb_data_d = ld;
        end else if (ir_q[7:6] == 2'b10) begin
          strb_d = 3'b010;
        end
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge oscillator) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      ir_q <= '0;
      regs_q <= '{default: '0};
      op_q <= '0;
      strb_q <= '0;
      wb_reg_q <= '0;
      wb_data_q <= '0;
      step_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      regs_q <= regs_d;
      op_q <= op_d;
      strb_q <= strb_d;
      wb_reg_q <= wb_reg_d;
      wb_data_q <= wb_data_d;
      step_q <= step;
    end
  end
  // lower half holds i, upper half holds -(i - DEPTH/2)
  always_ff @(posedge oscillator) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= (i < DEPTH / 2) ? DATA_W'(i) : DATA_W'(DEPTH / 2 - i);
    end else if (mem_we) begin
      mem_q[addr] <= rb;
    end
  end
endmodule

// File: tb/tb_step_core.sv
// tb_step_core: scoreboard bench for step_core; expected commits are queued at issue
// and retired by a negedge monitor whenever the core pulses a commit strobe.
module tb_step_core;
  logic oscillator = 1'b0, reset = 1'b0, run = 1'b0, step = 1'b0, instr_valid = 1'b1;
  logic [7:0] instruction = 8'h00;
  logic [4:0] dbg_addr = 5'd0;
  logic [7:0] instr_addr, wb_data, dbg_data;
  logic instr_req, mem_read, mem_write, reg_write, wb_valid, halted;
  logic [1:0] op, wb_reg;
  typedef struct packed {
    logic [1:0] op;
    logic mr, mw, rw;
    logic [1:0] rd;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;

  step_core dut (
    .oscillator(oscillator), .reset(reset), .run(run), .step(step),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_valid(instr_valid),
    .instruction(instruction), .op(op), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .wb_reg(wb_reg), .wb_data(wb_data), .wb_valid(wb_valid),
    .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 oscillator = ~oscillator;

  always @(negedge oscillator) begin
    if (mem_read || mem_write || reg_write || wb_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got mr=%0b mw=%0b rw=%0b wb=%0b, required no strobe",
                 mem_read, mem_write, reg_write, wb_valid);
      end else begin
        e = q.pop_front();
        if ({op, mem_read, mem_write, reg_write, wb_valid} !== {e.op, e.mr, e.mw, e.rw, e.rw}) begin
          errors++;
          $display("FAIL commit_strobes: got op=%0d mr/mw/rw/wb=%b%b%b%b, required op=%0d %b%b%b%b",
                   op, mem_read, mem_write, reg_write, wb_valid, e.op, e.mr, e.mw, e.rw, e.rw);
        end
        if (e.rw) begin
          checks++;
          if ({wb_reg, wb_data} !== {e.rd, e.data}) begin
            errors++;
            $display("FAIL writeback: got r%0d=%h, required r%0d=%h", wb_reg, wb_data, e.rd, e.data);
          end
        end
      end
    end
  end

  task automatic push(input logic [1:0] o, input logic mr, mw, rw, input logic [1:0] rd, input logic [7:0] d);
    q.push_back('{o, mr, mw, rw, rd, d});
  endtask

  task automatic issue(input logic [7:0] ins);
    int n = 0;
    while (!instr_req && n < 50) begin
      @(negedge oscillator);
      n++;
    end
    checks++;
    if (!instr_req) begin
      errors++;
      $display("FAIL fetch_timeout: instr_req=%0b after %0d cycles, required 1", instr_req, n);
    end
    instruction = ins;
    @(negedge oscillator);
  endtask

  task automatic do_reset();
    @(negedge oscillator);
    reset = 1'b1;
    run = 1'b0;
    step = 1'b0;
    instr_valid = 1'b1;
    instruction = 8'h00;
    @(negedge oscillator);
    @(negedge oscillator);
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] m;
    do_reset();
    checks++;
    if ({instr_addr, instr_req, op, mem_read, mem_write, reg_write, wb_valid, wb_reg, wb_data, halted} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pc=%h req=%b op=%0d strb=%b%b%b%b wb=r%0d/%h halt=%b, required all 0",
               instr_addr, instr_req, op, mem_read, mem_write, reg_write, wb_valid, wb_reg, wb_data, halted);
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      m = (i < 16) ? 8'(i) : 8'(16 - i);
      #1;
      checks++;
      if (dbg_data !== m) begin
        errors++;
        $display("FAIL reset_mem[%0d]: got %h, required %h", i, dbg_data, m);
      end
    end
  endtask

  task automatic test_load_add_store();
    do_reset();
    run = 1'b1;
    push(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 8'h01);
    issue(8'h45);
    @(negedge oscillator);
    checks++;
    if (instr_addr !== 8'd1) begin
      errors++;
      $display("FAIL load_pc: got %0d, required 1", instr_addr);
    end
    push(2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h02);
    issue(8'h16);
    push(2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    issue(8'h9B);
    run = 1'b0;
    @(negedge oscillator);
    @(negedge oscillator);
    dbg_addr = 5'd0;
    #1;
    checks++;
    if ({instr_addr, instr_req, op, wb_reg, wb_data, dbg_data} !== {8'd3, 1'b0, 2'd2, 2'd2, 8'h02, 8'h02}) begin
      errors++;
      $display("FAIL store_result: got pc=%0d req=%b op=%0d wb=r%0d/%h mem0=%h, required pc=3 req=0 op=2 wb=r2/02 mem0=02",
               instr_addr, instr_req, op, wb_reg, wb_data, dbg_data);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL store_pending: got %0d commits outstanding, required 0", q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run = 1'b1;
    push(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 8'hF1);
    issue(8'h47);
    push(2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 8'hF1);
    issue(8'h05);
    push(2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 8'hE2);
    issue(8'h15);
    run = 1'b0;
    @(negedge oscillator);
    @(negedge oscillator);
    checks++;
    if (instr_addr !== 8'd3 || q.size() != 0) begin
      errors++;
      $display("FAIL wrap_end: got pc=%0d pending=%0d, required pc=3 pending=0", instr_addr, q.size());
    end
  endtask

  task automatic test_step();
    int wbc = 0;
    do_reset();
    instruction = 8'h45;
    push(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 8'h01);
    step = 1'b1;
    repeat (10) begin
      @(negedge oscillator);
      if (wb_valid) wbc++;
    end
    checks++;
    if (wbc != 1 || instr_addr !== 8'd1 || instr_req !== 1'b0) begin
      errors++;
      $display("FAIL step_hold: got pulses=%0d pc=%0d req=%b, required pulses=1 pc=1 req=0", wbc, instr_addr, instr_req);
    end
    step = 1'b0;
    @(negedge oscillator);
    push(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 8'h01);
    step = 1'b1;
    repeat (4) @(negedge oscillator);
    step = 1'b0;
    checks++;
    if (instr_addr !== 8'd2 || q.size() != 0) begin
      errors++;
      $display("FAIL step_second: got pc=%0d pending=%0d, required pc=2 pending=0", instr_addr, q.size());
    end
  endtask

  task automatic test_step_ignored();
    do_reset();
    instr_valid = 1'b0;
    step = 1'b1;
    @(negedge oscillator);
    step = 1'b0;
    @(negedge oscillator);
    step = 1'b1;
    @(negedge oscillator);
    step = 1'b0;
    repeat (3) @(negedge oscillator);
    checks++;
    if (instr_req !== 1'b1 || instr_addr !== 8'd0) begin
      errors++;
      $display("FAIL step_stall: got req=%b pc=%0d, required req=1 pc=0", instr_req, instr_addr);
    end
    push(2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    instr_valid = 1'b1;
    repeat (6) @(negedge oscillator);
    checks++;
    if (instr_req !== 1'b0 || instr_addr !== 8'd1 || q.size() != 0) begin
      errors++;
      $display("FAIL step_not_queued: got req=%b pc=%0d pending=%0d, required req=0 pc=1 pending=0",
               instr_req, instr_addr, q.size());
    end
  endtask

  task automatic test_jump();
    do_reset();
    instruction = 8'hC1;
    step = 1'b1;
    @(negedge oscillator);
    step = 1'b0;
    repeat (3) @(negedge oscillator);
    checks++;
    if (instr_addr !== 8'd2 || op !== 2'd3 || halted !== 1'b0) begin
      errors++;
      $display("FAIL jump_fwd: got pc=%0d op=%0d halt=%b, required pc=2 op=3 halt=0", instr_addr, op, halted);
    end
    instruction = 8'hC2;
    step = 1'b1;
    @(negedge oscillator);
    step = 1'b0;
    repeat (3) @(negedge oscillator);
    checks++;
    if (instr_addr !== 8'd1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL jump_back: got pc=%0d halt=%b, required pc=1 halt=0", instr_addr, halted);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    do_reset();
    for (int i = 0; i < 9; i++) push(2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    run = 1'b1;
    while (q.size() > 1 && cyc < 100) begin
      @(negedge oscillator);
      #1;
      cyc++;
    end
    run = 1'b0;
    checks++;
    if (cyc > 17) begin
      errors++;
      $display("FAIL throughput: got 8 commits in %0d cycles, required at most 17", cyc);
    end
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      @(negedge oscillator);
      #1;
      cyc++;
    end
    @(negedge oscillator);
    checks++;
    if (instr_addr !== 8'd9 || q.size() != 0 || instr_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got pc=%0d pending=%0d req=%b, required pc=9 pending=0 req=0",
               instr_addr, q.size(), instr_req);
    end
  endtask

  task automatic test_stall_halt();
    do_reset();
    run = 1'b1;
    instr_valid = 1'b0;
    instruction = 8'h45;
    @(negedge oscillator);
    repeat (5) begin
      @(negedge oscillator);
      checks++;
      if (instr_req !== 1'b1 || instr_addr !== 8'd0) begin
        errors++;
        $display("FAIL stall: got req=%b pc=%0d, required req=1 pc=0", instr_req, instr_addr);
      end
    end
    instruction = 8'hC3;
    instr_valid = 1'b1;
    @(negedge oscillator);
    @(negedge oscillator);
    checks++;
    if (halted !== 1'b1 || instr_addr !== 8'd0 || op !== 2'd3) begin
      errors++;
      $display("FAIL halt_entry: got halt=%b pc=%0d op=%0d, required halt=1 pc=0 op=3", halted, instr_addr, op);
    end
    repeat (5) begin
      @(negedge oscillator);
      checks++;
      if (instr_req !== 1'b0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold: got req=%b halt=%b, required req=0 halt=1", instr_req, halted);
      end
    end
    do_reset();
    checks++;
    if (instr_addr !== 8'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: got pc=%0d halt=%b, required pc=0 halt=0", instr_addr, halted);
    end
  endtask

  task automatic test_reset_exec();
    do_reset();
    run = 1'b1;
    push(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 8'h01);
    issue(8'h45);
    push(2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h02);
    issue(8'h16);
    issue(8'h9B);
    reset = 1'b1;
    run = 1'b0;
    dbg_addr = 5'd0;
    @(negedge oscillator);
    checks++;
    if ({mem_write, dbg_data, instr_addr, wb_valid, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset_in_exec: got mw=%b mem0=%h pc=%0d wb=%b/%h, required all 0",
               mem_write, dbg_data, instr_addr, wb_valid, wb_data);
    end
    reset = 1'b0;
    @(negedge oscillator);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL reset_in_exec_pending: got %0d outstanding, required 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_add_store();
    test_wrap();
    test_step();
    test_step_ignored();
    test_jump();
    test_back_to_back();
    test_stall_halt();
    test_reset_exec();
    repeat (2) @(negedge oscillator);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
